vga_timing_gen: RTL
===================

Name: vga_timing_gen

Overview:
- Parametrised raster timing generator; successor to the fixed 1024x768 beam counter.
- Produces pixel coordinates, data-enable, polarity-configurable HSYNC/VSYNC, line/frame strobes and a frame counter for any VESA-style mode.
- Accepts a pixel-clock enable, so it can run from a faster system clock.
- Sync/DE outputs have a configurable extra delay so they line up with a downstream pixel-generation pipeline.

Parameters:
- H_VISIBLE, 1024, active pixels per line
- H_FRONT, 24, horizontal front porch (pixels)
- H_SYNC, 136, horizontal sync width (pixels)
- H_BACK, 160, horizontal back porch (pixels)
- V_VISIBLE, 768, active lines per frame
- V_FRONT, 3, vertical front porch (lines)
- V_SYNC, 6, vertical sync width (lines)
- V_BACK, 29, vertical back porch (lines)
- HSYNC_POL, 0, 1 = hsync active-high, 0 = active-low
- VSYNC_POL, 0, 1 = vsync active-high, 0 = active-low
- PIPE_DELAY, 0, extra enabled-cycle delay (0..4) applied to de/hsync/vsync/line_start/frame_start only
- FCNT_W, 16, frame counter width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- pix_en  in  1  pixel-clock enable; all state advances only on clk edges with pix_en=1
- x  out  HW  pixel column, HW = $clog2(H_TOTAL), H_TOTAL = sum of H_* params
- y  out  VW  pixel row, VW = $clog2(V_TOTAL), V_TOTAL = sum of V_* params
- de  out  1  high when (x,y) lies in the visible area (delayed by PIPE_DELAY)
- hsync  out  1  horizontal sync at HSYNC_POL polarity (delayed)
- vsync  out  1  vertical sync at VSYNC_POL polarity (delayed)
- line_start  out  1  strobe at x==0 of every line, including blanking lines (delayed)
- frame_start  out  1  strobe at x==0,y==0 (delayed)
- frame_cnt  out  FCNT_W  number of completed frames, wraps modulo 2^FCNT_W

Behaviour:
- Line layout, counter h from 0 to H_TOTAL-1:
  - visible: [0, H_VISIBLE)
  - front porch: [H_VISIBLE, +H_FRONT)
  - sync: next H_SYNC counts
  - back porch: remaining counts
- Vertical layout uses the same scheme with counter v and the V_* params.
- Counters:
  - On an enabled edge, h increments.
  - At h==H_TOTAL-1, h wraps to 0 and v increments.
  - At h==H_TOTAL-1 and v==V_TOTAL-1, both wrap to 0 and frame_cnt increments (modulo 2^FCNT_W).
- Output stage:
  - x/y/de/hsync/vsync/line_start/frame_start are registered from (h,v) on enabled edges, giving 1 enabled-cycle latency from the counters.
  - de/hsync/vsync/line_start/frame_start then pass through a PIPE_DELAY-deep shift register that also advances only on pix_en.
  - x/y are never delayed.
- Hold rule: with pix_en=0, every register holds. Strobes therefore stay high until the next enabled edge; consumers qualify them with pix_en.
- Derivation:
  - de = (h<H_VISIBLE) && (v<V_VISIBLE)
  - hsync asserted when h is in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC); vsync uses the same form on v. Asserted = drives the *_POL value.
  - line_start = (h==0); frame_start = (h==0 && v==0).
- vsync timing: vsync changes only at line boundaries (with h==0), never mid-line.
- Reset:
  - h=v=0, frame_cnt=0, x=y=0.
  - de=0, line_start=0, frame_start=0.
  - hsync=!HSYNC_POL, vsync=!VSYNC_POL.
  - Every delay-line stage is loaded with these same inactive values.
- After reset, the first enabled edge presents x=0,y=0, with de=1, line_start=1 and frame_start=1 appearing PIPE_DELAY enabled edges later.
- Reset mid-frame: takes effect on the next clk edge regardless of pix_en. No partial-frame frame_cnt increment.
- rst and pix_en high together: reset wins.
- Elaboration check: any H_*/V_* value <1, or PIPE_DELAY>4, is rejected with $error.

Test Plan:
- Small mode (H 8/2/3/3 → H_TOTAL=16; V 4/1/2/1 → V_TOTAL=8; PIPE_DELAY=0; pix_en=1 constant), 3 frames → de high for 8 consecutive cycles per line on lines 0..3 only; hsync low at h=10..12; vsync low on lines 5..6; frame_start exactly every 128 cycles; frame_cnt reaches 3.
- Same mode with HSYNC_POL=1, VSYNC_POL=1 → sync pulses invert; de/x/y are unchanged cycle-for-cycle.
- pix_en toggling 1,0,0,1,… (1 in 3) → sequence identical to the pix_en=1 run when sampled only on enabled edges; all outputs hold on disabled cycles.
- PIPE_DELAY=3 → de/hsync/vsync/line_start/frame_start lag the PIPE_DELAY=0 run by exactly 3 enabled cycles; x/y are identical.
- Reset asserted at h=5,v=2 for 2 cycles → next cycle shows x=0,y=0, frame_cnt=0, hsync/vsync inactive. frame_start appears on the first enabled edge after release (PIPE_DELAY=0).
- Default 1024x768 params, run one full frame → H_TOTAL=1344, V_TOTAL=806; exactly 1024×768 de-high cycles; 806 line_start strobes; 1 frame_start strobe.

Source files
------------

// File: rtl/vga_timing_gen.sv
// Parametrised VESA-style raster timing generator: pixel coordinates, data-enable,
// polarity-configurable syncs, line/frame strobes and a frame counter, gated by pix_en.
module vga_timing_gen #(
   parameter int H_VISIBLE  = 1024,
   parameter int H_FRONT    = 24,
   parameter int H_SYNC     = 136,
   parameter int H_BACK     = 160,
   parameter int V_VISIBLE  = 768,
   parameter int V_FRONT    = 3,
   parameter int V_SYNC     = 6,
   parameter int V_BACK     = 29,
   parameter int HSYNC_POL  = 0,
   parameter int VSYNC_POL  = 0,
   parameter int PIPE_DELAY = 0,
   parameter int FCNT_W     = 16,
   localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK,
   localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK,
   localparam int HW        = $clog2(H_TOTAL),
   localparam int VW        = $clog2(V_TOTAL)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pix_en,
   output logic [HW-1:0]     x,
   output logic [VW-1:0]     y,
   output logic              de,
   output logic              hsync,
   output logic              vsync,
   output logic              line_start,
   output logic              frame_start,
   output logic [FCNT_W-1:0] frame_cnt
);

   localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_VIS  = HW'(H_VISIBLE);
   localparam logic [HW-1:0] HS_BEG = HW'(H_VISIBLE + H_FRONT);
   localparam logic [HW-1:0] HS_END = HW'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_VIS  = VW'(V_VISIBLE);
   localparam logic [VW-1:0] VS_BEG = VW'(V_VISIBLE + V_FRONT);
   localparam logic [VW-1:0] VS_END = VW'(V_VISIBLE + V_FRONT + V_SYNC);
   localparam logic          HS_ON  = (HSYNC_POL != 0);
   localparam logic          VS_ON  = (VSYNC_POL != 0);
   // Control bundle order: {de, hsync, vsync, line_start, frame_start}
   localparam logic [4:0]    CTL_IDLE = {1'b0, ~HS_ON, ~VS_ON, 1'b0, 1'b0};

   if (H_VISIBLE < 1 || H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
       V_VISIBLE < 1 || V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1) begin : g_bad_timing
      $error("vga_timing_gen: all H_*/V_* timing parameters must be >= 1");
   end
   if (PIPE_DELAY < 0 || PIPE_DELAY > 4) begin : g_bad_delay
      $error("vga_timing_gen: PIPE_DELAY must be in 0..4");
   end

   logic [HW-1:0]     h_q, h_d, x_q, x_d;
   logic [VW-1:0]     v_q, v_d, y_q, y_d;
   logic [FCNT_W-1:0] fcnt_q, fcnt_d;
   logic [4:0]        ctl_q, ctl_d, ctl_out;
   logic              de_s, hs_act_s, vs_act_s;

   always_comb begin
      h_d    = h_q;
      v_d    = v_q;
      fcnt_d = fcnt_q;
      if (rst) begin
         h_d    = {HW{1'b0}};
         v_d    = {VW{1'b0}};
         fcnt_d = {FCNT_W{1'b0}};
      end else if (pix_en) begin
         if (h_q == H_LAST) begin
            h_d = {HW{1'b0}};
            if (v_q == V_LAST) begin
               v_d    = {VW{1'b0}};
               fcnt_d = fcnt_q + 1'b1;
            end else begin
               v_d = v_q + 1'b1;
            end
         end else begin
            h_d = h_q + 1'b1;
         end
      end else begin
         h_d = h_q;
      end
   end

   always_comb begin
      de_s     = (h_q < H_VIS) && (v_q < V_VIS);
      hs_act_s = (h_q >= HS_BEG) && (h_q < HS_END);
      vs_act_s = (v_q >= VS_BEG) && (v_q < VS_END);
   end

   // Output stage: one enabled cycle behind the counters
   always_comb begin
      x_d   = x_q;
      y_d   = y_q;
      ctl_d = ctl_q;
      if (rst) begin
         x_d   = {HW{1'b0}};
         y_d   = {VW{1'b0}};
         ctl_d = CTL_IDLE;
      end else if (pix_en) begin
         x_d   = h_q;
         y_d   = v_q;
         ctl_d = {de_s,
                  hs_act_s ? HS_ON : ~HS_ON,
                  vs_act_s ? VS_ON : ~VS_ON,
                  (h_q == {HW{1'b0}}),
                  (h_q == {HW{1'b0}}) && (v_q == {VW{1'b0}})};
      end else begin
         ctl_d = ctl_q;
      end
   end

   always_ff @(posedge clk) begin
      h_q    <= h_d;
      v_q    <= v_d;
      fcnt_q <= fcnt_d;
      x_q    <= x_d;
      y_q    <= y_d;
      ctl_q  <= ctl_d;
   end

   if (PIPE_DELAY > 0) begin : g_dly
      logic [4:0] pipe_q [PIPE_DELAY];
      logic [4:0] pipe_d [PIPE_DELAY];

      // Alignment delay for the control bundle; advances with the pixel clock only
      always_comb begin
         for (int i = 0; i < PIPE_DELAY; i++) begin
            pipe_d[i] = pipe_q[i];
         end
         if (rst) begin
            for (int i = 0; i < PIPE_DELAY; i++) begin
               pipe_d[i] = CTL_IDLE;
            end
         end else if (pix_en) begin
            pipe_d[0] = ctl_q;
            for (int i = 1; i < PIPE_DELAY; i++) begin
               pipe_d[i] = pipe_q[i-1];
            end
         end else begin
            pipe_d[0] = pipe_q[0];
         end
      end

      always_ff @(posedge clk) begin
         for (int i = 0; i < PIPE_DELAY; i++) begin
            pipe_q[i] <= pipe_d[i];
         end
      end

      assign ctl_out = pipe_q[PIPE_DELAY-1];
   end else begin : g_nodly
      assign ctl_out = ctl_q;
   end

   assign x         = x_q;
   assign y         = y_q;
   assign frame_cnt = fcnt_q;
   assign {de, hsync, vsync, line_start, frame_start} = ctl_out;

endmodule
